// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param: multicycle instruction sequencer (IF/ID/EX/MEM/WB) with a
// memory-wait timeout, halt-at-boundary handling and a retired-instruction
// counter. All outputs are registered and decoded from the next state.
// Opcode, rd and the other inputs are registered into the outputs, so they
// must be stable from IF until the instruction ends.
module ctrl_fsm_param #(
  parameter int REG_ADDR_W  = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16,
  localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_in,
  input  logic                  en1,
  input  logic                  en2,
  input  logic                  pc_jump,
  input  logic                  halt_req,
  input  logic                  ram_valid,
  input  logic [3:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  en_fetch_pulse,
  output logic                  en_pc_pulse,
  output logic                  en_group_pulse,
  output logic [1:0]            pc_ctrl,
  output logic [NUM_REGS-1:0]   reg_en,
  output logic                  alu_in_sel,
  output logic [2:0]            alu_func,
  output logic                  ram_en,
  output logic                  wen,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_W-1:0]      retired
);

  // opcode[3] selects the class: 0 = ALU/jump (EX), 1 = memory (MEM)
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_ANDI  = 4'd5;
  localparam logic [3:0] OP_MOVI  = 4'd6;
  localparam logic [3:0] OP_JUMP  = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_ERR} state_e;

  state_e                state_q, state_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [7:0]            mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0]      retired_q, retired_d;
  logic                  fetch_lvl_q, fetch_lvl_d;
  logic                  pc_lvl_q, pc_lvl_d;
  logic                  grp_lvl_q, grp_lvl_d;
  logic                  en_fetch_pulse_q, en_pc_pulse_q, en_group_pulse_q;
  logic [1:0]            pc_ctrl_q, pc_ctrl_d;
  logic [NUM_REGS-1:0]   reg_en_q, reg_en_d;
  logic                  alu_in_sel_q, alu_in_sel_d;
  logic [2:0]            alu_func_q, alu_func_d;
  logic                  ram_en_q, ram_en_d;
  logic                  wen_q, wen_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  halt_now;
  logic                  retire;

  function automatic logic is_alu_op(input logic [3:0] op);
    return !op[3];
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Next-state, MEM wait counter, halt bookkeeping and retire counting
  always_comb begin
    state_d   = state_q;
    mem_cnt_d = '0;
    retire    = 1'b0;
    halt_now  = halt_pend_q | halt_req;
    case (state_q)
      S_IDLE: if (en_in && !halt_req) state_d = S_IF;
      S_IF:   if (en1) state_d = S_ID;
      S_ID: begin
        if (opcode[3]) begin
          state_d   = S_MEM;
          mem_cnt_d = 8'd1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        // an opcode outside the ALU class here retires as a one-cycle NOP
        if (!is_alu_op(opcode)) retire = 1'b1;
        else if (en2)           state_d = S_WB;
        else if (pc_jump)       retire = 1'b1;
      end
      S_MEM: begin
        if (!is_mem_op(opcode)) begin
          retire = 1'b1;
        end else if (ram_valid) begin
          if (opcode == OP_LOAD) state_d = S_WB;
          else                   retire  = 1'b1;
        end else if (mem_cnt_q >= 8'(MEM_TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          state_d   = S_MEM;
          mem_cnt_d = mem_cnt_q + 8'd1;
        end
      end
      S_WB:  retire = 1'b1;
      S_ERR: if (!en_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = halt_now ? S_IDLE : S_IF;
    retired_d   = retire ? retired_q + CNT_W'(1) : retired_q;
    halt_pend_d = (state_d == S_IDLE) ? 1'b0 : halt_now;
  end

  // Output decode from the state being entered, so outputs line up with state_q
  always_comb begin
    fetch_lvl_d  = 1'b0;
    pc_lvl_d     = 1'b0;
    grp_lvl_d    = 1'b0;
    pc_ctrl_d    = 2'b00;
    reg_en_d     = '0;
    alu_in_sel_d = 1'b0;
    alu_func_d   = ALU_ADD;
    ram_en_d     = 1'b0;
    wen_d        = 1'b0;
    busy_d       = (state_d != S_IDLE) && (state_d != S_ERR);
    err_d        = (state_d == S_ERR);
    case (state_d)
      S_IF: begin
        fetch_lvl_d = 1'b1;
        pc_lvl_d    = 1'b1;
        pc_ctrl_d   = 2'b01;
      end
      S_EX: begin
        case (opcode)
          OP_ADD:  begin grp_lvl_d = 1'b1; alu_in_sel_d = 1'b1; alu_func_d = ALU_ADD; end
          OP_SUB:  begin grp_lvl_d = 1'b1; alu_in_sel_d = 1'b1; alu_func_d = ALU_SUB; end
          OP_AND:  begin grp_lvl_d = 1'b1; alu_in_sel_d = 1'b1; alu_func_d = ALU_AND; end
          OP_OR:   begin grp_lvl_d = 1'b1; alu_in_sel_d = 1'b1; alu_func_d = ALU_OR;  end
          OP_ADDI: begin grp_lvl_d = 1'b1; alu_func_d = ALU_ADD; end
          OP_ANDI: begin grp_lvl_d = 1'b1; alu_func_d = ALU_AND; end
          OP_MOVI: begin grp_lvl_d = 1'b1; alu_func_d = ALU_ADD; end
          OP_JUMP: begin pc_lvl_d  = 1'b1; pc_ctrl_d = 2'b10; end
          default: ;
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LOAD) begin
          ram_en_d = 1'b1;
        end else if (opcode == OP_STORE) begin
          ram_en_d  = 1'b1;
          wen_d     = 1'b1;
          grp_lvl_d = 1'b1;
        end
      end
      S_WB: reg_en_d[rd] = 1'b1;
      default: ;
    endcase
  end

  // State, counters, level history, strobes and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      halt_pend_q      <= 1'b0;
      mem_cnt_q        <= '0;
      retired_q        <= '0;
      fetch_lvl_q      <= 1'b0;
      pc_lvl_q         <= 1'b0;
      grp_lvl_q        <= 1'b0;
      en_fetch_pulse_q <= 1'b0;
      en_pc_pulse_q    <= 1'b0;
      en_group_pulse_q <= 1'b0;
      pc_ctrl_q        <= 2'b00;
      reg_en_q         <= '0;
      alu_in_sel_q     <= 1'b0;
      alu_func_q       <= ALU_ADD;
      ram_en_q         <= 1'b0;
      wen_q            <= 1'b0;
      busy_q           <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      halt_pend_q      <= halt_pend_d;
      mem_cnt_q        <= mem_cnt_d;
      retired_q        <= retired_d;
      fetch_lvl_q      <= fetch_lvl_d;
      pc_lvl_q         <= pc_lvl_d;
      grp_lvl_q        <= grp_lvl_d;
      en_fetch_pulse_q <= fetch_lvl_d & ~fetch_lvl_q;
      en_pc_pulse_q    <= pc_lvl_d & ~pc_lvl_q;
      en_group_pulse_q <= grp_lvl_d & ~grp_lvl_q;
      pc_ctrl_q        <= pc_ctrl_d;
      reg_en_q         <= reg_en_d;
      alu_in_sel_q     <= alu_in_sel_d;
      alu_func_q       <= alu_func_d;
      ram_en_q         <= ram_en_d;
      wen_q            <= wen_d;
      busy_q           <= busy_d;
      err_q            <= err_d;
    end
  end

  assign en_fetch_pulse = en_fetch_pulse_q;
  assign en_pc_pulse    = en_pc_pulse_q;
  assign en_group_pulse = en_group_pulse_q;
  assign pc_ctrl        = pc_ctrl_q;
  assign reg_en         = reg_en_q;
  assign alu_in_sel     = alu_in_sel_q;
  assign alu_func       = alu_func_q;
  assign ram_en         = ram_en_q;
  assign wen            = wen_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// tb_ctrl_fsm_param: drives two instances (4-register/16-bit counter and
// 8-register/4-bit counter) with the same instruction stream and compares
// every output each cycle against a phase-timeline reference model.
module tb_ctrl_fsm_param;

  localparam int TMO = 15;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4, OP_ANDI = 4'd5, OP_MOVI = 4'd6, OP_JUMP = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8, OP_STORE = 4'd9;

  localparam int P_IDLE = 0, P_IF = 1, P_ID = 2, P_EX = 3, P_MEM = 4, P_WB = 5, P_ERR = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_in = 1'b0, en1 = 1'b0, en2 = 1'b0, pc_jump = 1'b0;
  logic       halt_req = 1'b0, ram_valid = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [2:0] rd = 3'd0;

  logic       fp4, pp4, gp4, sel4, ram4, wen4, busy4, err4;
  logic [1:0] pcc4;
  logic [2:0] func4;
  logic [3:0] reg4;
  logic [15:0] ret4;
  logic       fp8, pp8, gp8, sel8, ram8, wen8, busy8, err8;
  logic [1:0] pcc8;
  logic [2:0] func8;
  logic [7:0] reg8;
  logic [3:0] ret8;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;
  logic [2:0] prev_lv = 3'b000;
  logic [3:0] cur_op = 4'd0;
  logic [2:0] cur_rd = 3'd0;
  bit in_idle = 1'b1;

  always #5 clk = ~clk;

  ctrl_fsm_param #(.REG_ADDR_W(2), .MEM_TIMEOUT(TMO), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .en1(en1), .en2(en2), .pc_jump(pc_jump),
    .halt_req(halt_req), .ram_valid(ram_valid), .opcode(opcode), .rd(rd[1:0]),
    .en_fetch_pulse(fp4), .en_pc_pulse(pp4), .en_group_pulse(gp4), .pc_ctrl(pcc4),
    .reg_en(reg4), .alu_in_sel(sel4), .alu_func(func4), .ram_en(ram4), .wen(wen4),
    .busy(busy4), .err(err4), .retired(ret4));

  ctrl_fsm_param #(.REG_ADDR_W(3), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .en1(en1), .en2(en2), .pc_jump(pc_jump),
    .halt_req(halt_req), .ram_valid(ram_valid), .opcode(opcode), .rd(rd),
    .en_fetch_pulse(fp8), .en_pc_pulse(pp8), .en_group_pulse(gp8), .pc_ctrl(pcc8),
    .reg_en(reg8), .alu_in_sel(sel8), .alu_func(func8), .ram_en(ram8), .wen(wen8),
    .busy(busy8), .err(err8), .retired(ret8));

  // one comparison: count it, report it if it differs
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {group, pc, fetch} levels implied by a phase and opcode
  function automatic logic [2:0] levels(input int ph, input logic [3:0] op);
    logic [2:0] lv;
    lv[0] = (ph == P_IF);
    lv[1] = (ph == P_IF) || (ph == P_EX && op == OP_JUMP);
    lv[2] = (ph == P_EX && op <= OP_MOVI) || (ph == P_MEM && op == OP_STORE);
    return lv;
  endfunction

  task automatic check_outputs(input int ph);
    logic [2:0] lv, pl;
    logic [1:0] e_pcc;
    logic       e_sel, e_ram, e_wen, e_busy, e_err;
    logic [2:0] e_func;
    logic [7:0] e_reg8;
    logic [3:0] e_reg4;
    logic [31:0] r;
    lv = levels(ph, cur_op);
    pl = lv & ~prev_lv;
    e_pcc  = (ph == P_IF) ? 2'b01 : (ph == P_EX && cur_op == OP_JUMP) ? 2'b10 : 2'b00;
    e_sel  = (ph == P_EX) && (cur_op <= OP_OR);
    e_func = 3'd0;
    if (ph == P_EX) begin
      if (cur_op == OP_SUB) e_func = 3'd1;
      else if (cur_op == OP_AND || cur_op == OP_ANDI) e_func = 3'd2;
      else if (cur_op == OP_OR) e_func = 3'd3;
    end
    e_ram  = (ph == P_MEM) && (cur_op == OP_LOAD || cur_op == OP_STORE);
    e_wen  = (ph == P_MEM) && (cur_op == OP_STORE);
    e_reg8 = (ph == P_WB) ? (8'd1 << cur_rd) : 8'd0;
    e_reg4 = (ph == P_WB) ? (4'd1 << cur_rd[1:0]) : 4'd0;
    e_busy = (ph != P_IDLE) && (ph != P_ERR);
    e_err  = (ph == P_ERR);
    r = exp_ret;
    chk("d4.fetch_pulse", fp4, pl[0]);   chk("d8.fetch_pulse", fp8, pl[0]);
    chk("d4.pc_pulse", pp4, pl[1]);      chk("d8.pc_pulse", pp8, pl[1]);
    chk("d4.group_pulse", gp4, pl[2]);   chk("d8.group_pulse", gp8, pl[2]);
    chk("d4.pc_ctrl", pcc4, e_pcc);      chk("d8.pc_ctrl", pcc8, e_pcc);
    chk("d4.alu_in_sel", sel4, e_sel);   chk("d8.alu_in_sel", sel8, e_sel);
    chk("d4.alu_func", func4, e_func);   chk("d8.alu_func", func8, e_func);
    chk("d4.ram_en", ram4, e_ram);       chk("d8.ram_en", ram8, e_ram);
    chk("d4.wen", wen4, e_wen);          chk("d8.wen", wen8, e_wen);
    chk("d4.reg_en", reg4, e_reg4);      chk("d8.reg_en", reg8, e_reg8);
    chk("d4.busy", busy4, e_busy);       chk("d8.busy", busy8, e_busy);
    chk("d4.err", err4, e_err);          chk("d8.err", err8, e_err);
    chk("d4.retired", ret4, {16'd0, r[15:0]});
    chk("d8.retired", ret8, {28'd0, r[3:0]});
  endtask

  // check the phase the DUT should be in now, then let one clock edge pass
  task automatic cyc(input int ph);
    check_outputs(ph);
    prev_lv = levels(ph, cur_op);
    @(posedge clk);
    #1;
  endtask

  // one instruction starting in IF; ended_idle tells where it leaves the DUT
  task automatic run_instr(input logic [3:0] op, input logic [2:0] r, input int d1,
                           input int d2, input int mode, input int halt_at,
                           output bit ended_idle);
    opcode = op; rd = r; cur_op = op; cur_rd = r;
    ended_idle = (halt_at != 0);
    for (int i = 0; i <= d1; i++) begin en1 = (i == d1); cyc(P_IF); end
    en1 = 1'b0;
    halt_req = (halt_at == 1);
    cyc(P_ID);
    halt_req = 1'b0;
    if (!op[3]) begin
      for (int i = 0; i <= d2; i++) begin
        en2      = (i == d2) && (mode != 1);
        pc_jump  = (i == d2) && (mode != 0);
        halt_req = (i == d2) && (mode == 1) && (halt_at == 2);
        cyc(P_EX);
      end
      en2 = 1'b0; pc_jump = 1'b0;
      if (mode != 1) begin halt_req = (halt_at == 2); cyc(P_WB); end
      halt_req = 1'b0;
      exp_ret++;
    end else if (op == OP_LOAD || op == OP_STORE) begin
      if (d2 >= TMO) begin
        ram_valid = 1'b0;
        for (int i = 0; i < TMO; i++) cyc(P_MEM);
        en_in = 1'b1;
        cyc(P_ERR); cyc(P_ERR);
        en_in = 1'b0;
        cyc(P_ERR);
        en_in = 1'b1;
        ended_idle = 1'b1;
      end else begin
        for (int i = 0; i <= d2; i++) begin
          ram_valid = (i == d2);
          halt_req  = (i == d2) && (op == OP_STORE) && (halt_at == 2);
          cyc(P_MEM);
        end
        ram_valid = 1'b0;
        if (op == OP_LOAD) begin halt_req = (halt_at == 2); cyc(P_WB); end
        halt_req = 1'b0;
        exp_ret++;
      end
    end else begin
      halt_req = (halt_at == 2);
      cyc(P_MEM);
      halt_req = 1'b0;
      exp_ret++;
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [2:0] r, input int d1,
                          input int d2, input int mode, input int halt_at);
    bit ei;
    if (in_idle) begin halt_req = 1'b0; en_in = 1'b1; cyc(P_IDLE); end
    run_instr(op, r, d1, d2, mode, halt_at, ei);
    in_idle = ei;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rsel, d2;
    logic [3:0] op;
    // reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    check_outputs(P_IDLE);
    #3 rst_n = 1'b1;
    cyc(P_IDLE);

    do_instr(OP_ADDI, 3'd2, 2, 1, 0, 0);        // basic immediate op through WB
    do_instr(OP_LOAD, 3'd3, 0, 2, 0, 0);        // valid on 3rd MEM cycle
    do_instr(OP_STORE, 3'd1, 1, 2, 0, 0);       // store, no writeback
    do_instr(OP_LOAD, 3'd1, 0, TMO, 0, 0);      // timeout into ERR and out
    do_instr(OP_LOAD, 3'd5, 0, TMO - 1, 0, 0);  // valid in the last allowed cycle
    do_instr(OP_ADD, 3'd0, 0, 0, 0, 1);         // halt pulsed in ID
    halt_req = 1'b1; en_in = 1'b1;
    repeat (3) cyc(P_IDLE);                     // held halt keeps IDLE
    halt_req = 1'b0;
    do_instr(OP_JUMP, 3'd6, 0, 1, 2, 0);        // en2 and pc_jump together
    do_instr(OP_JUMP, 3'd6, 0, 2, 1, 0);        // pc_jump only
    do_instr(4'd12, 3'd4, 0, 0, 0, 0);          // undefined memory-class op
    for (int r = 0; r < 8; r++) do_instr(OP_SUB, 3'(r), 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      rsel = $urandom_range(0, 11);
      if (rsel <= 9) op = 4'(rsel);
      else op = 4'(10 + $urandom_range(0, 5));
      if (op[3]) begin
        rsel = $urandom_range(0, 9);
        d2 = (rsel <= 5) ? rsel : (rsel <= 7) ? TMO - 1 : (rsel == 8) ? TMO : 3;
      end else begin
        d2 = $urandom_range(0, 3);
      end
      do_instr(op, 3'($urandom_range(0, 7)), $urandom_range(0, 3), d2,
               $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      if (in_idle && $urandom_range(0, 1) == 1) begin
        halt_req = 1'b1;
        cyc(P_IDLE);
        halt_req = 1'b0;
      end
    end

    // asynchronous reset in the middle of a memory access
    if (in_idle) begin en_in = 1'b1; cyc(P_IDLE); end
    opcode = OP_STORE; cur_op = OP_STORE;
    en1 = 1'b1; cyc(P_IF);
    en1 = 1'b0; cyc(P_ID);
    cyc(P_MEM); cyc(P_MEM);
    check_outputs(P_MEM);
    #1 rst_n = 1'b0; en_in = 1'b0;
    #1;
    exp_ret = 0;
    prev_lv = 3'b000;
    check_outputs(P_IDLE);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_idle = 1'b1;
    do_instr(OP_OR, 3'd7, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_param.md
CTRL_FSM_PARAM -- requirements
Module: ctrl_fsm_param

Interface
REQ-001 Parameter REG_ADDR_W, default 2, register-index width; NUM_REGS = 2**REG_ADDR_W is derived, not set.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum cycles spent in MEM waiting for ram_valid (legal range 1..255).
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en_in  in  1  run enable; en1 in 1 fetch done; en2 in 1 ALU result ready; pc_jump in 1 jump target loaded.
REQ-007 halt_req  in  1  request stop at next instruction boundary; ram_valid in 1 memory access complete.
REQ-008 opcode  in  4  current instruction opcode; rd in REG_ADDR_W destination register index.
REQ-009 en_fetch_pulse, en_pc_pulse, en_group_pulse  out  1 each  single-cycle strobes.
REQ-010 pc_ctrl out 2; reg_en out NUM_REGS one-hot write enable; alu_in_sel out 1; alu_func out 3; ram_en out 1; wen out 1.
REQ-011 busy out 1 (state not IDLE/ERR); err out 1 (memory timeout); retired out CNT_W.

Function
REQ-012 States IDLE, IF, ID, EX, MEM, WB, ERR; state register only on clk/rst_n.
REQ-013 IDLE->IF when en_in=1 and halt_req=0; else hold.
REQ-014 IF->ID when en1=1; else hold.
REQ-015 ID->EX when opcode[3]=0; ID->MEM when opcode[3]=1; always one cycle.
REQ-016 EX: en2=1 -> WB; else pc_jump=1 -> instruction end; else hold; en2 wins if both high.
REQ-017 EX with undefined ALU-class opcode -> instruction end after one cycle (NOP), counted as retired.
REQ-018 MEM: ram_valid=1 with LOAD -> WB; ram_valid=1 with STORE -> instruction end (no writeback).
REQ-019 MEM: cycle counter starts at 1 on MEM entry; ram_valid low in the MEM_TIMEOUT-th cycle -> ERR; ram_valid high in that cycle completes normally.
REQ-020 MEM with undefined memory-class opcode -> instruction end next cycle, ram_en stays 0.
REQ-021 WB -> instruction end after one cycle.
REQ-022 Instruction end: next state IDLE if halt pending, else IF; retired increments by 1, wraps to 0 at 2**CNT_W.
REQ-023 halt_req=1 in any cycle sets halt pending; cleared on entry to IDLE; halt_req while IDLE keeps state IDLE.
REQ-024 ERR: err=1, all control outputs 0; exit to IDLE only when en_in=0; err clears on that exit.
REQ-025 Outputs decoded from current state (Moore) plus opcode/rd; all unlisted outputs 0, alu_func=ALU_ADD default.
REQ-026 IF: fetch level=1, pc level=1, pc_ctrl=01.
REQ-027 EX: ADD/SUB/AND/OR group level=1, alu_in_sel=1; ADDI/ANDI/MOVI group level=1, alu_in_sel=0; alu_func ADD/SUB/AND/OR per op (MOVI/ADDI=ADD, ANDI=AND).
REQ-028 EX JUMP: pc level=1, pc_ctrl=10, group level=0.
REQ-029 MEM LOAD: ram_en=1, wen=0; MEM STORE: ram_en=1, wen=1, group level=1.
REQ-030 WB: reg_en bit rd high only, exactly one bit for every rd value.
REQ-031 Each *_pulse = its level AND NOT its level registered one cycle earlier; high only in first cycle of a level run.

Reset
REQ-032 rst_n low: state IDLE, halt pending 0, MEM counter 0, retired 0, err 0, pulse history 0, all outputs 0, alu_func=ALU_ADD, immediately and asynchronously.
REQ-033 Reset asserted mid-MEM drops ram_en and wen in the same cycle; no retire count for the aborted instruction.

Verification
REQ-034 ADDI rd=2, en1 after 2 cycles, en2 after 1 -> IF,ID,EX,WB; en_fetch_pulse 1 cycle; reg_en=0100 in WB only; retired=1.
REQ-035 LOAD, ram_valid on 3rd MEM cycle -> ram_en 3 cycles, wen=0, WB reg_en one-hot; STORE same -> wen=1, no WB, retired+1.
REQ-036 LOAD, ram_valid never (MEM_TIMEOUT=15) -> ERR after exactly 15 MEM cycles, err=1, retired unchanged; en_in=0 -> IDLE, err=0.
REQ-037 halt_req pulsed in ID of ADD -> instruction completes through WB, then IDLE, busy=0; en_in held high, no new IF until halt_req low.
REQ-038 JUMP with en2 and pc_jump high same EX cycle -> WB taken; JUMP with pc_jump only -> IF next, pc_ctrl=10 in EX, en_pc_pulse once.
REQ-039 REG_ADDR_W=3, sweep rd 0..7 -> reg_en 8-bit one-hot; CNT_W=4 after 16 retires -> retired wraps to 0.
